// File: rtl/conv33_ctrl.sv
// Frame-level sequencer for the 3x3 convolution engine: walks every valid output
// position in raster order and runs fetch -> start -> capture -> write for each one.
module conv33_ctrl #(
   parameter int IMG_W      = 28,
   parameter int IMG_H      = 28,
   parameter int CNT_WIDTH  = 8,
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  go,
   input  logic                  abort,
   output logic                  busy,
   output logic                  frame_done,
   output logic                  win_req,
   output logic [CNT_WIDTH-1:0]  win_row,
   output logic [CNT_WIDTH-1:0]  win_col,
   input  logic                  win_ack,
   output logic                  calc_start,
   input  logic                  calc_valid,
   output logic                  calc_ready,
   output logic                  out_we,
   output logic [ADDR_WIDTH-1:0] out_addr,
   input  logic                  out_ready,
   output logic [2:0]            state_dbg
);

   // Handshakes: win_req/win_ack, calc_ready/calc_valid and out_we/out_ready each
   // complete at a rising edge where both are high; the requester holds its
   // request and payload unchanged until that edge.

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_REQ   = 3'd1,
      S_CALC  = 3'd2,
      S_WAIT  = 3'd3,
      S_WRITE = 3'd4
   } state_t;

   localparam logic [CNT_WIDTH-1:0] COL_LAST = CNT_WIDTH'(IMG_W - 3);
   localparam logic [CNT_WIDTH-1:0] ROW_LAST = CNT_WIDTH'(IMG_H - 3);

   state_t                  state_q, state_d;
   logic [CNT_WIDTH-1:0]    row_q, row_d, col_q, col_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic                    busy_q, busy_d;
   logic                    frame_done_q, frame_done_d;
   logic                    win_req_q, win_req_d;
   logic                    calc_start_q, calc_start_d;
   logic                    calc_ready_q, calc_ready_d;
   logic                    out_we_q, out_we_d;
   logic                    last_pos;

   always_comb begin
      state_d      = state_q;
      row_d        = row_q;
      col_d        = col_q;
      addr_d       = addr_q;
      frame_done_d = 1'b0;
      last_pos     = (row_q == ROW_LAST) && (col_q == COL_LAST);

      case (state_q)
         S_IDLE: begin
            if (go && !abort) begin
               state_d = S_REQ;
               row_d   = '0;
               col_d   = '0;
               addr_d  = '0;
            end
         end
         S_REQ: begin
            if (win_ack) state_d = S_CALC;
         end
         S_CALC: state_d = S_WAIT;
         S_WAIT: begin
            if (calc_valid) state_d = S_WRITE;
         end
         S_WRITE: begin
            if (out_ready) begin
               if (last_pos) begin
                  state_d      = S_IDLE;
                  row_d        = '0;
                  col_d        = '0;
                  addr_d       = '0;
                  frame_done_d = 1'b1;
               end else begin
                  state_d = S_REQ;
                  addr_d  = addr_q + ADDR_WIDTH'(1);
                  if (col_q == COL_LAST) begin
                     col_d = '0;
                     row_d = row_q + CNT_WIDTH'(1);
                  end else begin
                     col_d = col_q + CNT_WIDTH'(1);
                  end
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Abort overrides every other transition out of a busy state.
      if (abort && (state_q != S_IDLE)) begin
         state_d      = S_IDLE;
         row_d        = '0;
         col_d        = '0;
         addr_d       = '0;
         frame_done_d = 1'b0;
      end

      // Outputs are registered copies of the next-state decode.
      busy_d       = (state_d != S_IDLE);
      win_req_d    = (state_d == S_REQ);
      calc_start_d = (state_d == S_CALC);
      calc_ready_d = (state_d == S_WAIT);
      out_we_d     = (state_d == S_WRITE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         row_q        <= '0;
         col_q        <= '0;
         addr_q       <= '0;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
         win_req_q    <= 1'b0;
         calc_start_q <= 1'b0;
         calc_ready_q <= 1'b0;
         out_we_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         row_q        <= row_d;
         col_q        <= col_d;
         addr_q       <= addr_d;
         busy_q       <= busy_d;
         frame_done_q <= frame_done_d;
         win_req_q    <= win_req_d;
         calc_start_q <= calc_start_d;
         calc_ready_q <= calc_ready_d;
         out_we_q     <= out_we_d;
      end
   end

   assign busy       = busy_q;
   assign frame_done = frame_done_q;
   assign win_req    = win_req_q;
   assign win_row    = row_q;
   assign win_col    = col_q;
   assign calc_start = calc_start_q;
   assign calc_ready = calc_ready_q;
   assign out_we     = out_we_q;
   assign out_addr   = addr_q;
   assign state_dbg  = state_q;

endmodule

// File: tb/tb_conv33_ctrl.sv
// Bench for conv33_ctrl on a non-square 5x4 map: scoreboard of expected windows,
// addresses and frame completions, with random and directed backpressure.
module tb_conv33_ctrl;

   localparam int IMG_W   = 5;
   localparam int IMG_H   = 4;
   localparam int CW      = 4;
   localparam int AW      = 4;
   localparam int OUT_W   = IMG_W - 2;
   localparam int OUT_H   = IMG_H - 2;
   localparam int N       = OUT_W * OUT_H;
   localparam int TIMEOUT = 40 * N + 100;

   logic          clk = 1'b0;
   logic          rst;
   logic          go, abort;
   logic          busy, frame_done, win_req, calc_start, calc_ready, out_we;
   logic [CW-1:0] win_row, win_col;
   logic [AW-1:0] out_addr;
   logic          win_ack, calc_valid, out_ready;
   logic [2:0]    state_dbg;

   conv33_ctrl #(.IMG_W(IMG_W), .IMG_H(IMG_H), .CNT_WIDTH(CW), .ADDR_WIDTH(AW)) dut (
      .clk(clk), .rst(rst), .go(go), .abort(abort), .busy(busy), .frame_done(frame_done),
      .win_req(win_req), .win_row(win_row), .win_col(win_col), .win_ack(win_ack),
      .calc_start(calc_start), .calc_valid(calc_valid), .calc_ready(calc_ready),
      .out_we(out_we), .out_addr(out_addr), .out_ready(out_ready), .state_dbg(state_dbg)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   // Engine model: valid_out one cycle after start.
   always @(posedge clk or posedge rst) begin
      if (rst) calc_valid <= 1'b0;
      else     calc_valid <= calc_start;
   end

   // ---------------- scoreboard state ----------------
   logic [2*CW-1:0] exp_win_q[$];
   logic [AW-1:0]   exp_addr_q[$];
   logic [0:0]      exp_done_q[$];
   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [63:0] outs();
      return 64'({busy, frame_done, win_req, calc_start, calc_ready, out_we,
                  win_row, win_col, out_addr});
   endfunction

   // Reference: a frame is the raster list of window origins with linear addresses.
   task automatic push_frame();
      for (int i = 0; i < N; i++) begin
         exp_win_q.push_back({CW'(i / OUT_W), CW'(i % OUT_W)});
         exp_addr_q.push_back(AW'(i));
      end
      exp_done_q.push_back(1'b1);
   endtask

   // ---------------- response drivers ----------------
   int ack_pct = 100, rdy_pct = 100;
   int ack_blk_cnt = 0, rdy_blk_cnt = 0;
   logic [CW-1:0] ack_blk_row = '0, ack_blk_col = '0;
   logic [AW-1:0] rdy_blk_addr = '0;

   always @(posedge clk) begin
      #1;
      win_ack   = ($urandom_range(0, 99) < ack_pct);
      out_ready = ($urandom_range(0, 99) < rdy_pct);
      if (win_req && ack_blk_cnt > 0 && win_row == ack_blk_row && win_col == ack_blk_col) begin
         win_ack = 1'b0;
         ack_blk_cnt--;
      end
      if (out_we && rdy_blk_cnt > 0 && out_addr == rdy_blk_addr) begin
         out_ready = 1'b0;
         rdy_blk_cnt--;
      end
   end

   // ---------------- monitor ----------------
   int cyc = 0, starts = 0, stalls = 0;
   logic prev_start = 0, prev_win_hs = 0, prev_we_stall = 0, prev_req_stall = 0, prev_abort = 0;
   logic chk_idle = 0;
   logic [AW-1:0] prev_addr = '0;
   logic [CW-1:0] prev_row = '0, prev_col = '0;

   always @(negedge clk) begin
      if (rst) begin
         exp_win_q.delete(); exp_addr_q.delete(); exp_done_q.delete();
         cyc = 0; starts = 0; stalls = 0; chk_idle = 0;
         prev_start = 0; prev_win_hs = 0; prev_we_stall = 0; prev_req_stall = 0; prev_abort = 0;
      end else begin
         if (chk_idle) begin
            chk("abort_outputs_zero", outs(), 64'd0);
            chk_idle = 0;
         end
         if (!prev_abort && prev_we_stall)
            chk("write_hold", 64'({out_we, out_addr}), 64'({1'b1, prev_addr}));
         if (!prev_abort && prev_req_stall)
            chk("req_hold", 64'({win_req, win_row, win_col}), 64'({1'b1, prev_row, prev_col}));
         if (calc_start) begin
            chk("start_single", 64'(prev_start), 64'd0);
            chk("start_after_ack", 64'(prev_win_hs), 64'd1);
            starts++;
         end
         if (!abort && win_req && win_ack) begin
            if (exp_win_q.size() == 0) chk("win_unexpected", 64'd1, 64'd0);
            else chk("win_rowcol", 64'({win_row, win_col}), 64'(exp_win_q.pop_front()));
         end
         if (!abort && out_we && out_ready) begin
            if (exp_addr_q.size() == 0) chk("write_unexpected", 64'd1, 64'd0);
            else chk("write_addr", 64'(out_addr), 64'(exp_addr_q.pop_front()));
         end
         if (busy) cyc++;
         if ((win_req && !win_ack) || (out_we && !out_ready)) stalls++;
         if (frame_done) begin
            if (exp_done_q.size() == 0) chk("done_unexpected", 64'd1, 64'd0);
            else begin
               void'(exp_done_q.pop_front());
               chk("frame_len", 64'(cyc), 64'(4 * N + stalls));
               chk("frame_starts", 64'(starts), 64'(N));
               chk("done_busy_low", 64'(busy), 64'd0);
            end
            cyc = 0; starts = 0; stalls = 0;
         end
         prev_start     = calc_start;
         prev_win_hs    = win_req && win_ack && !abort;
         prev_we_stall  = out_we && !out_ready;
         prev_req_stall = win_req && !win_ack;
         prev_addr      = out_addr;
         prev_row       = win_row;
         prev_col       = win_col;
         prev_abort     = abort && busy;
         if (abort && busy) begin
            exp_win_q.delete(); exp_addr_q.delete(); exp_done_q.delete();
            cyc = 0; starts = 0; stalls = 0;
            chk_idle = 1;
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic run_frame(input int pa, input int pb, input int exp_len);
      int n;
      bit seen;
      push_frame();
      go = 1'b1;
      @(posedge clk); #1;
      go = 1'b0;
      chk("go_busy_req", 64'({busy, win_req}), 64'd3);
      n = 0;
      seen = 0;
      while (!seen && n <= TIMEOUT) begin
         if (frame_done) seen = 1;
         else begin
            @(posedge clk); #1;
            n++;
            go = (n == pa) || (n == pb);
         end
      end
      go = 1'b0;
      if (!seen) chk("frame_timeout", 64'd0, 64'd1);
      else if (exp_len >= 0) chk("frame_done_cycle", 64'(n), 64'(exp_len));
   endtask

   initial begin
      int n;
      go = 0; abort = 0; rst = 1;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_outputs", outs(), 64'd0);
      rst = 0;
      @(posedge clk); #1;
      chk("idle_after_reset", outs(), 64'd0);

      // Nominal frame, no backpressure.
      run_frame(-1, -1, 4 * N);
      repeat (2) @(posedge clk);
      #1;

      // Write stall on addr 2, ack delay on window (1,0), go pulses while busy.
      rdy_blk_addr = AW'(2); rdy_blk_cnt = 3;
      ack_blk_row = CW'(1); ack_blk_col = CW'(0); ack_blk_cnt = 5;
      run_frame(2, 7, 4 * N + 8);
      repeat (2) @(posedge clk);
      #1;

      // go and abort together in IDLE: abort wins.
      go = 1; abort = 1;
      @(posedge clk); #1;
      go = 0; abort = 0;
      chk("go_abort_idle", 64'(busy), 64'd0);

      // Abort mid-frame at cycle 9.
      push_frame();
      go = 1;
      @(posedge clk); #1;
      go = 0;
      repeat (9) @(posedge clk);
      #1;
      abort = 1;
      @(posedge clk); #1;
      abort = 0;
      chk("abort_idle_c10", outs(), 64'd0);
      repeat (6) @(posedge clk);
      #1;
      run_frame(-1, -1, 4 * N);

      // Random backpressure, back-to-back frames.
      ack_pct = 60; rdy_pct = 60;
      for (int f = 0; f < 4; f++) run_frame(-1, -1, -1);

      // Asynchronous reset during a WRITE.
      push_frame();
      go = 1;
      @(posedge clk); #1;
      go = 0;
      n = 0;
      while (!out_we && n < TIMEOUT) begin
         @(posedge clk); #1;
         n++;
      end
      chk("reach_write", 64'(out_we), 64'd1);
      rst = 1;
      #1;
      chk("async_reset_outputs", outs(), 64'd0);
      repeat (2) @(posedge clk);
      #1;
      rst = 0;
      ack_pct = 100; rdy_pct = 100;
      @(posedge clk); #1;
      run_frame(-1, -1, 4 * N);
      run_frame(-1, -1, 4 * N);

      repeat (4) @(posedge clk);
      #1;
      chk("queues_drained", 64'(exp_win_q.size() + exp_addr_q.size() + exp_done_q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/conv33_ctrl.md
# conv33_ctrl

Frame-level sequencer for the 3x3 convolution engine. On `go` it walks every valid output position of an IMG_H x IMG_W feature map (stride 1, no padding) in raster order. For each position it:
- requests the 3x3 window from the window/line-buffer fetch unit;
- fires the engine's single-cycle `start`;
- captures the engine's `valid_out`;
- issues a handshaked write of the result to the output buffer.

It sits between the top-level layer controller and the conv engine / feature-map memories.

## Interface
Parameters:
- IMG_W, 28, input map width (≥3)
- IMG_H, 28, input map height (≥3)
- CNT_WIDTH, 8, width of row/col counters (must hold IMG_W-3 and IMG_H-3)
- ADDR_WIDTH, 10, output address width (must hold (IMG_W-2)*(IMG_H-2)-1)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- go  in  1  frame start request; sampled only in IDLE
- abort  in  1  synchronous frame abort
- busy  out  1  high whenever state ≠ IDLE
- frame_done  out  1  one-cycle pulse after last write accepted
- win_req  out  1  window fetch request
- win_row  out  CNT_WIDTH  top-left row of requested window
- win_col  out  CNT_WIDTH  top-left col of requested window
- win_ack  in  1  window data stable at engine inputs
- calc_start  out  1  to engine `start`
- calc_valid  in  1  from engine `valid_out`
- calc_ready  out  1  to engine `ready_in`
- out_we  out  1  output write request (engine `result` is the data)
- out_addr  out  ADDR_WIDTH  output linear address
- out_ready  in  1  output buffer accepts write

## Operation
- OUT_W = IMG_W-2, OUT_H = IMG_H-2, N = OUT_W*OUT_H positions.
- States: IDLE, REQ, CALC, WAIT, WRITE.
- IDLE:
  - go=1 → REQ; row, col and out_addr cleared to 0.
  - go=0 → stay.
- REQ:
  - win_req=1, win_row=row, win_col=col.
  - win_ack=1 at a clock edge → CALC; otherwise hold.
- CALC: calc_start=1 for exactly this one cycle → WAIT.
- WAIT:
  - calc_ready=1.
  - calc_valid=1 → WRITE; otherwise stay.
  - The engine asserts valid_out the cycle after start, so WAIT lasts 1 cycle nominally.
- WRITE:
  - out_we=1, out_addr = current index.
  - The engine `result` stays stable because calc_start stays low.
  - out_ready=1 and position is last (row=OUT_H-1, col=OUT_W-1) → IDLE, frame_done=1 for the following cycle.
  - out_ready=1 and not last → advance:
    - col+1;
    - if col=OUT_W-1, then col=0 and row+1;
    - out_addr+1;
    - → REQ.
  - out_ready=0 → hold all outputs.
- Outputs are registered or decoded from state only; no combinational path from an input to an output.
- Counters never wrap past OUT_W-1 / OUT_H-1 / N-1.
- abort=1 in any non-IDLE state → IDLE next edge:
  - no frame_done;
  - counters cleared;
  - abort has priority over all other transitions.
- go while busy: ignored, not queued.
- go and abort both high in IDLE: abort wins; stay IDLE.

## Timing
- Reset value of every output is 0; state IDLE; counters 0.
- Async reset mid-frame: all outputs 0 immediately; no frame_done.
- go sampled high at edge E0 → busy=1 and win_req=1 from E0.
- Per-position minimum is 4 cycles (REQ, CALC, WAIT, WRITE) with win_ack and out_ready held high.
- Each cycle of win_ack=0 in REQ or out_ready=0 in WRITE adds one cycle.
- Frame minimum is 4*N cycles from go acceptance to the last out_we.
- frame_done is asserted in the cycle after the final WRITE handshake, concurrent with busy=0.
- The next go is accepted in that same cycle.
- calc_start is never high in two consecutive cycles.
- There is exactly one calc_start and one out_we handshake per position.

## Test plan
- IMG_W=IMG_H=4, win_ack/out_ready tied 1, model engine valid 1 cycle after start, go at cycle 0:
  - windows (0,0),(0,1),(1,0),(1,1) at out_addr 0..3;
  - 4 calc_start pulses;
  - frame_done at cycle 16;
  - busy low at cycle 16.
- Backpressure:
  - out_ready low for 3 cycles during WRITE of addr 2 → out_we/out_addr=2 held 3 cycles;
  - no extra calc_start;
  - frame_done at cycle 19.
- win_ack delayed 5 cycles on window (1,0):
  - win_req/win_row=1/win_col=0 stable throughout;
  - calc_start only after ack.
- go pulsed at cycles 2 and 7 during busy:
  - no counter reset;
  - single frame_done.
- abort at cycle 9 (mid-frame):
  - IDLE at cycle 10, all outputs 0, no frame_done;
  - a subsequent go restarts at (0,0), addr 0.
- rst asserted mid-WRITE:
  - all outputs 0 asynchronously;
  - after release, go runs a full clean frame;
  - back-to-back go in the frame_done cycle starts a second frame with no idle gap.
